waveform_pwm_output: RTL and testbench

Output stage placed directly downstream of `top_triangle_generator`. It selects one of the three generated waveforms (sawtooth, triangle or square pulse) and latches that waveform's samples on their valid strobes. Each sample is converted to an offset-binary duty value and driven as a single-bit PWM stream for an external RC DAC. At every PWM frame boundary the block issues `next_data_strobe_o`, which feeds `next_data_strobe_i` of the generator and sets the sample rate.

---
 rtl/waveform_pwm_output.sv | 179 +++++++++++++++++
 tb/tb_waveform_pwm_output.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/waveform_pwm_output.sv
// -----------------------------------------------------------------------------
// waveform_pwm_output
//
// Output stage that follows the triangle/sawtooth/square generator. It picks one
// source with select_i and captures that source's samples on their valid
// strobes. Each sample is turned into an offset-binary duty value. The duty is
// driven out as a single-bit PWM stream with a frame of F = 2^(N_FRAC+1)
// cycles. Every frame boundary issues next_data_strobe_o, and that strobe sets
// the generator's sample rate.
//
// Ports
//   clk_i                            clock
//   rst_i                            asynchronous active-low reset
//   enable_i                         run request (a drop takes effect at frame end)
//   select_i[1:0]                    00 sawtooth, 01 triangle, 10 square, 11 off
//   data_*_i[N_FRAC:0]               signed samples from the generator
//   data_*_valid_strobe_i            one-cycle strobes for each sample
//   next_data_strobe_o               one-cycle request, first cycle of each frame
//   pwm_o                            PWM stream for the external RC DAC
//   duty_o[N_FRAC:0]                 unsigned duty of the current frame
//   underrun_o                       one-cycle pulse when a frame starts without
//                                    a fresh sample
// -----------------------------------------------------------------------------
module waveform_pwm_output #(
    parameter int N_FRAC = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [1:0]        select_i,
    input  logic [N_FRAC:0]   data_sawtooth_i,
    input  logic [N_FRAC:0]   data_triangle_i,
    input  logic [N_FRAC:0]   data_square_puls_i,
    input  logic              data_sawtooth_valid_strobe_i,
    input  logic              data_triangle_valid_strobe_i,
    input  logic              data_square_puls_valid_strobe_i,
    output logic              next_data_strobe_o,
    output logic              pwm_o,
    output logic [N_FRAC:0]   duty_o,
    output logic              underrun_o
);

    localparam int W = N_FRAC + 1;
    localparam logic [W-1:0] MID_SCALE = {1'b1, {N_FRAC{1'b0}}};
    localparam logic [W-1:0] CNT_LAST  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_ZERO  = {W{1'b0}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_r;
    logic [W-1:0]    cnt_r;
    logic [W-1:0]    pending_r;
    logic            pending_valid_r;
    logic [1:0]      sel_q_r;

    logic            cap_hit_s;
    logic [W-1:0]    cap_data_s;
    logic            boundary_s;
    logic            off_s;

    // Route the strobe/data pair of the selected source; off mode captures nothing.
    always_comb begin
        cap_hit_s  = 1'b0;
        cap_data_s = {W{1'b0}};
        case (select_i)
            2'b00: begin
                cap_hit_s  = data_sawtooth_valid_strobe_i;
                cap_data_s = data_sawtooth_i;
            end
            2'b01: begin
                cap_hit_s  = data_triangle_valid_strobe_i;
                cap_data_s = data_triangle_i;
            end
            2'b10: begin
                cap_hit_s  = data_square_puls_valid_strobe_i;
                cap_data_s = data_square_puls_i;
            end
            default: begin
                cap_hit_s  = 1'b0;
                cap_data_s = {W{1'b0}};
            end
        endcase
    end

    // A frame starts on IDLE->RUN entry or on wrap of the last count while enabled.
    always_comb begin
        off_s = (select_i == 2'b11);
        if (enable_i && ((state_r == IDLE) || (cnt_r == CNT_LAST))) begin
            boundary_s = 1'b1;
        end else begin
            boundary_s = 1'b0;
        end
    end

    // Frame FSM, capture/boundary bookkeeping and the registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r            <= IDLE;
            cnt_r              <= CNT_ZERO;
            duty_o             <= MID_SCALE;
            pending_r          <= MID_SCALE;
            pending_valid_r    <= 1'b0;
            sel_q_r            <= 2'b00;
            pwm_o              <= 1'b0;
            next_data_strobe_o <= 1'b0;
            underrun_o         <= 1'b0;
        end else begin
            sel_q_r            <= select_i;
            // PWM uses pre-edge count and duty, so it lags cnt by one cycle.
            pwm_o              <= (state_r == RUN) && (cnt_r < duty_o);
            next_data_strobe_o <= boundary_s;
            underrun_o         <= 1'b0;

            case (state_r)
                IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (enable_i) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (enable_i) begin
                            state_r <= RUN;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase

            // The boundary consumes the pre-edge pending sample. A capture in
            // the same cycle is applied below and lands in the next frame.
            if (boundary_s) begin
                pending_valid_r <= 1'b0;
                if (off_s) begin
                    duty_o <= MID_SCALE;
                end else if (pending_valid_r) begin
                    duty_o <= pending_r;
                end else begin
                    duty_o     <= duty_o;
                    underrun_o <= (state_r == RUN);
                end
            end else begin
                duty_o <= duty_o;
            end

            // A source switch drops any sample taken from the old source.
            if (select_i != sel_q_r) begin
                pending_valid_r <= 1'b0;
            end else begin
                sel_q_r <= select_i;
            end

            // Offset binary: invert the sign bit. The last strobe in a frame wins.
            if (cap_hit_s) begin
                pending_r       <= {~cap_data_s[W-1], cap_data_s[W-2:0]};
                pending_valid_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

endmodule

// File: tb/tb_waveform_pwm_output.sv
module tb_waveform_pwm_output;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       enable_i;
    logic [1:0] select_i;
    logic [7:0] data_sawtooth_i, data_triangle_i, data_square_puls_i;
    logic       saw_stb, tri_stb, sq_stb;
    logic       next_data_strobe_o, pwm_o, underrun_o;
    logic [7:0] duty_o;

    int errors = 0;
    int checks = 0;
    int hi_n, nds_n, und_n;

    int         ev_at [3];
    logic [1:0] ev_ch [3];
    logic [7:0] ev_d  [3];
    int         sel_at;
    logic [1:0] sel_val;
    int         en_at;

    waveform_pwm_output #(.N_FRAC(7)) dut (
        .clk_i                           (clk_i),
        .rst_i                           (rst_i),
        .enable_i                        (enable_i),
        .select_i                        (select_i),
        .data_sawtooth_i                 (data_sawtooth_i),
        .data_triangle_i                 (data_triangle_i),
        .data_square_puls_i              (data_square_puls_i),
        .data_sawtooth_valid_strobe_i    (saw_stb),
        .data_triangle_valid_strobe_i    (tri_stb),
        .data_square_puls_valid_strobe_i (sq_stb),
        .next_data_strobe_o              (next_data_strobe_o),
        .pwm_o                           (pwm_o),
        .duty_o                          (duty_o),
        .underrun_o                      (underrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        hi_n  += int'(pwm_o);
        nds_n += int'(next_data_strobe_o);
        und_n += int'(underrun_o);
    endtask

    task automatic clear_events();
        for (int e = 0; e < 3; e++) ev_at[e] = -1;
        sel_at = -1;
        en_at  = -1;
    endtask

    // Runs one frame of 256 cycles, starting just after a boundary edge.
    // Tick i samples at the edge where cnt == i.
    task automatic run_frame();
        hi_n = 0; nds_n = 0; und_n = 0;
        for (int i = 0; i < 256; i++) begin
            for (int e = 0; e < 3; e++) begin
                if (ev_at[e] == i) begin
                    case (ev_ch[e])
                        2'd0: begin data_sawtooth_i = ev_d[e]; saw_stb = 1'b1; end
                        2'd1: begin data_triangle_i = ev_d[e]; tri_stb = 1'b1; end
                        default: begin data_square_puls_i = ev_d[e]; sq_stb = 1'b1; end
                    endcase
                end
            end
            if (sel_at == i) select_i = sel_val;
            if (en_at == i) enable_i = 1'b0;
            tick();
            saw_stb = 1'b0; tri_stb = 1'b0; sq_stb = 1'b0;
        end
        clear_events();
    endtask

    task automatic check_frame(input string tag, input int e_hi, input int e_nds,
                               input int e_und, input int e_duty);
        check({tag, "_high_cycles"}, hi_n, e_hi);
        check({tag, "_next_strobes"}, nds_n, e_nds);
        check({tag, "_underruns"}, und_n, e_und);
        check({tag, "_duty"}, int'(duty_o), e_duty);
    endtask

    initial begin
        rst_i = 1'b0; enable_i = 1'b0; select_i = 2'b01;
        data_sawtooth_i = 8'h00; data_triangle_i = 8'h00; data_square_puls_i = 8'h00;
        saw_stb = 1'b0; tri_stb = 1'b0; sq_stb = 1'b0;
        clear_events();
        repeat (3) tick();
        check("rst_pwm", int'(pwm_o), 0);
        check("rst_duty", int'(duty_o), 128);
        check("rst_nds", int'(next_data_strobe_o), 0);
        check("rst_und", int'(underrun_o), 0);

        rst_i = 1'b1;
        repeat (3) tick();
        check("idle_nds", int'(next_data_strobe_o), 0);

        // Entry from IDLE: request issued, no underrun.
        enable_i = 1'b1;
        tick();
        check("entry_nds", int'(next_data_strobe_o), 1);
        check("entry_und", int'(underrun_o), 0);

        // F1 duty 128; triangle -128 -> duty 0.
        ev_at[0] = 10; ev_ch[0] = 2'd1; ev_d[0] = 8'h80;
        run_frame();
        check_frame("f1", 128, 1, 0, 0);

        // F2 duty 0; triangle 127 -> duty 255.
        ev_at[0] = 20; ev_ch[0] = 2'd1; ev_d[0] = 8'h7F;
        run_frame();
        check_frame("f2", 0, 1, 0, 255);

        // F3 duty 255; tri 10, saw -100 (ignored), tri 20 -> 148.
        ev_at[0] = 5; ev_ch[0] = 2'd1; ev_d[0] = 8'd10;
        ev_at[1] = 6; ev_ch[1] = 2'd0; ev_d[1] = 8'h9C;
        ev_at[2] = 7; ev_ch[2] = 2'd1; ev_d[2] = 8'd20;
        run_frame();
        check_frame("f3", 255, 1, 0, 148);

        // F4: strobe on the boundary cycle; this boundary underruns.
        ev_at[0] = 255; ev_ch[0] = 2'd1; ev_d[0] = 8'd30;
        run_frame();
        check_frame("f4_coincident", 148, 1, 1, 148);

        // F5: the coincident sample lands now.
        run_frame();
        check_frame("f5_late_apply", 148, 1, 0, 158);

        // F6: no strobe -> underrun, duty held.
        run_frame();
        check_frame("f6_underrun", 158, 1, 1, 158);

        // F7: strobe -> no underrun.
        ev_at[0] = 100; ev_ch[0] = 2'd1; ev_d[0] = 8'd40;
        run_frame();
        check_frame("f7_recover", 158, 1, 0, 168);

        // F8: triangle 50 captured, then switch to sawtooth -> discarded.
        ev_at[0] = 50; ev_ch[0] = 2'd1; ev_d[0] = 8'd50;
        sel_at = 60; sel_val = 2'b00;
        run_frame();
        check_frame("f8_sel_change", 168, 1, 1, 168);

        // F9: sawtooth -28 -> 100.
        ev_at[0] = 30; ev_ch[0] = 2'd0; ev_d[0] = 8'hE4;
        run_frame();
        check_frame("f9_sawtooth", 168, 1, 0, 100);

        // F10: off mode; sawtooth strobe ignored; mid-scale, no underrun.
        sel_at = 0; sel_val = 2'b11;
        ev_at[0] = 10; ev_ch[0] = 2'd0; ev_d[0] = 8'd5;
        run_frame();
        check_frame("f10_off", 100, 1, 0, 128);

        // F11: back to triangle, 127 -> 255.
        sel_at = 5; sel_val = 2'b01;
        ev_at[0] = 10; ev_ch[0] = 2'd1; ev_d[0] = 8'h7F;
        run_frame();
        check_frame("f11_reselect", 128, 1, 0, 255);

        // F12: disable at cnt 37; the frame completes, then IDLE.
        en_at = 37;
        run_frame();
        check_frame("f12_disable", 255, 0, 0, 255);
        hi_n = 0; nds_n = 0; und_n = 0;
        repeat (40) tick();
        check("idle_high_cycles", hi_n, 0);
        check("idle_next_strobes", nds_n, 0);

        // Re-enter, then reset mid-frame while pwm is high.
        enable_i = 1'b1;
        tick();
        check("reentry_nds", int'(next_data_strobe_o), 1);
        check("reentry_und", int'(underrun_o), 0);
        repeat (5) tick();
        check("pre_reset_pwm", int'(pwm_o), 1);
        #3;
        rst_i = 1'b0;
        #1;
        check("async_rst_pwm", int'(pwm_o), 0);
        check("async_rst_duty", int'(duty_o), 128);
        check("async_rst_nds", int'(next_data_strobe_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
